// File: rtl/voice_mix_scheduler_if.sv
// Voice fetch handshake between the mix scheduler (master) and the voice sample store (slave).
interface voice_mix_scheduler_if #(
  parameter int unsigned NUM_VOICES   = 8,
  parameter int unsigned SAMPLE_WIDTH = 16
);
  localparam int unsigned IDX_W = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;

  logic                           voice_req;
  logic [IDX_W-1:0]               voice_idx;
  logic                           voice_valid;
  logic signed [SAMPLE_WIDTH-1:0] voice_sample;

  modport master (
    output voice_req,
    output voice_idx,
    input  voice_valid,
    input  voice_sample
  );

  modport slave (
    input  voice_req,
    input  voice_idx,
    output voice_valid,
    output voice_sample
  );
endinterface

// File: rtl/voice_mix_scheduler.sv
// Time-multiplexed gain/MAC mixer over NUM_VOICES voices with a saturating output clipper.
// Optional VOICE_MIX_CLIP_COUNT_EN adds a saturating count of clipped frames (clip_count).

// Saturates a signed WIDTH_FULL value into WIDTH_CLIP bits.
module sat_clip #(
  parameter int unsigned WIDTH_FULL = 24,
  parameter int unsigned WIDTH_CLIP = 16
) (
  input  logic signed [WIDTH_FULL-1:0] din,
  output logic signed [WIDTH_CLIP-1:0] dout_c,
  output logic                         clipped_c
);
  localparam int unsigned HI_W = WIDTH_FULL - WIDTH_CLIP + 1;

  logic [HI_W-1:0] hi;

  always_comb begin
    hi        = din[WIDTH_FULL-1:WIDTH_CLIP-1];
    clipped_c = !((hi == '0) || (hi == '1));
    if (!clipped_c) begin
      dout_c = din[WIDTH_CLIP-1:0];
    end else if (din[WIDTH_FULL-1]) begin
      dout_c = {1'b1, {(WIDTH_CLIP-1){1'b0}}};
    end else begin
      dout_c = {1'b0, {(WIDTH_CLIP-1){1'b1}}};
    end
  end
endmodule

module voice_mix_scheduler #(
  parameter int unsigned NUM_VOICES   = 8,
  parameter int unsigned SAMPLE_WIDTH = 16,
  parameter int unsigned GAIN_WIDTH   = 8
) (
  input  logic                               clk_in,
  input  logic                               rst_in,
  input  logic                               sample_tick,
  input  logic [NUM_VOICES*GAIN_WIDTH-1:0]   gain_in,
  voice_mix_scheduler_if.master              voice,
  output logic signed [SAMPLE_WIDTH-1:0]     mix_out,
  output logic                               mix_valid,
  output logic                               busy,
  output logic                               overrun
`ifdef VOICE_MIX_CLIP_COUNT_EN
  ,
  output logic [15:0]                        clip_count
`endif
);
  localparam int unsigned IDX_W  = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
  localparam int unsigned PROD_W = SAMPLE_WIDTH + GAIN_WIDTH + 1;
  localparam int unsigned ACC_W  = SAMPLE_WIDTH + GAIN_WIDTH - 7 + $clog2(NUM_VOICES) + 1;

  typedef enum logic [1:0] {IDLE, REQ, WAIT, CLIP} state_t;

  state_t                    state, state_next;
  logic signed [ACC_W-1:0]   acc, acc_next, acc_sum;
  logic [IDX_W-1:0]          idx_next;
  logic                      req_next, mixv_next, busy_next, overrun_next;
  logic signed [SAMPLE_WIDTH-1:0] mix_next, clip_val;
  logic                      clip_oor;
  logic [GAIN_WIDTH-1:0]     gain_sel;
  logic signed [GAIN_WIDTH:0] gain_s;
  logic signed [PROD_W-1:0]  prod, term;
  logic                      last_voice;
`ifdef VOICE_MIX_CLIP_COUNT_EN
  logic [15:0]               clip_count_next;
`endif

  // Gain for the voice currently being fetched, sampled in the cycle the product is formed.
  always_comb begin
    gain_sel = '0;
    for (int unsigned v = 0; v < NUM_VOICES; v++) begin
      if (voice.voice_idx == IDX_W'(v)) begin
        gain_sel = gain_in[v*GAIN_WIDTH +: GAIN_WIDTH];
      end
    end
  end

  // Full-precision signed x unsigned product, Q1.7 rescale, then accumulate.
  always_comb begin
    gain_s  = {1'b0, gain_sel};
    prod    = PROD_W'(voice.voice_sample) * PROD_W'(gain_s);
    term    = prod >>> 7;
    acc_sum = acc + ACC_W'(term);
  end

  sat_clip #(
    .WIDTH_FULL (ACC_W),
    .WIDTH_CLIP (SAMPLE_WIDTH)
  ) u_clip (
    .din       (acc_sum),
    .dout_c    (clip_val),
    .clipped_c (clip_oor)
  );

  assign last_voice = (voice.voice_idx == IDX_W'(NUM_VOICES - 1));

  // Next-state and registered-output values; the final clip is taken on the WAIT->CLIP edge
  // so mix_out and mix_valid appear together in the CLIP cycle.
  always_comb begin
    state_next   = state;
    acc_next     = acc;
    idx_next     = voice.voice_idx;
    req_next     = 1'b0;
    mixv_next    = 1'b0;
    mix_next     = mix_out;
    overrun_next = overrun | (sample_tick & (state != IDLE));
`ifdef VOICE_MIX_CLIP_COUNT_EN
    clip_count_next = clip_count;
`endif
    case (state)
      IDLE: begin
        if (sample_tick) begin
          state_next = REQ;
          acc_next   = '0;
          idx_next   = '0;
          req_next   = 1'b1;
        end
      end
      REQ: begin
        state_next = WAIT;
      end
      WAIT: begin
        if (voice.voice_valid) begin
          acc_next = acc_sum;
          if (last_voice) begin
            state_next = CLIP;
            mixv_next  = 1'b1;
            mix_next   = clip_val;
`ifdef VOICE_MIX_CLIP_COUNT_EN
            if (clip_oor && (clip_count != 16'hFFFF)) begin
              clip_count_next = clip_count + 16'd1;
            end
`endif
          end else begin
            state_next = REQ;
            idx_next   = voice.voice_idx + IDX_W'(1);
            req_next   = 1'b1;
          end
        end
      end
      CLIP: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
    busy_next = (state_next != IDLE);
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state           <= IDLE;
      acc             <= '0;
      voice.voice_idx <= '0;
      voice.voice_req <= 1'b0;
      mix_out         <= '0;
      mix_valid       <= 1'b0;
      busy            <= 1'b0;
      overrun         <= 1'b0;
`ifdef VOICE_MIX_CLIP_COUNT_EN
      clip_count      <= 16'd0;
`endif
    end else begin
      state           <= state_next;
      acc             <= acc_next;
      voice.voice_idx <= idx_next;
      voice.voice_req <= req_next;
      mix_out         <= mix_next;
      mix_valid       <= mixv_next;
      busy            <= busy_next;
      overrun         <= overrun_next;
`ifdef VOICE_MIX_CLIP_COUNT_EN
      clip_count      <= clip_count_next;
`endif
    end
  end
endmodule

// File: tb/tb_voice_mix_scheduler.sv
// Randomized self-checking bench for voice_mix_scheduler against a plain-arithmetic mixing model.
module tb_voice_mix_scheduler;
  localparam int NV = 4;
  localparam int SW = 16;
  localparam int GW = 8;
  localparam int IW = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                 rst;
  logic                 tick;
  logic [NV*GW-1:0]     gain_in;
  logic signed [SW-1:0] mix_out;
  logic                 mix_valid;
  logic                 busy;
  logic                 overrun;
`ifdef VOICE_MIX_CLIP_COUNT_EN
  logic [15:0]          clip_count;
`endif

  voice_mix_scheduler_if #(.NUM_VOICES(NV), .SAMPLE_WIDTH(SW)) vif ();

  voice_mix_scheduler #(
    .NUM_VOICES   (NV),
    .SAMPLE_WIDTH (SW),
    .GAIN_WIDTH   (GW)
  ) dut (
    .clk_in      (clk),
    .rst_in      (rst),
    .sample_tick (tick),
    .gain_in     (gain_in),
    .voice       (vif),
    .mix_out     (mix_out),
    .mix_valid   (mix_valid),
    .busy        (busy),
    .overrun     (overrun)
`ifdef VOICE_MIX_CLIP_COUNT_EN
    ,
    .clip_count  (clip_count)
`endif
  );

  int checks = 0;
  int errors = 0;
  int samples [NV];
  int gains   [NV];
  int fix_delay;
  int exp_clips;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference: each voice contributes floor(sample*gain/128); the sum saturates to 16 bits.
  function automatic int floor_div128(input int p);
    return (p >= 0) ? (p / 128) : -((-p + 127) / 128);
  endfunction

  function automatic int ref_acc();
    int a = 0;
    for (int v = 0; v < NV; v++) a += floor_div128(samples[v] * gains[v]);
    return a;
  endfunction

  function automatic int clip16(input int a);
    if (a > 32767)  return 32767;
    if (a < -32768) return -32768;
    return a;
  endfunction

  // Voice store: answers each request after fix_delay cycles (or 1..20 at random when 0).
  always begin : responder
    logic [IW-1:0] idx;
    int d;
    bit aborted;
    @(negedge clk);
    if (!rst && vif.voice_req === 1'b1) begin
      idx     = vif.voice_idx;
      d       = (fix_delay > 0) ? fix_delay : int'($urandom_range(20, 1));
      aborted = 1'b0;
      for (int k = 1; k <= d; k++) begin
        @(posedge clk);
        if (k == d) begin
          #1;
          vif.voice_valid  = 1'b1;
          vif.voice_sample = 16'(samples[idx]);
        end
        @(negedge clk);
        if (rst) aborted = 1'b1;
        if (!aborted) check("idx_hold", int'(vif.voice_idx), int'(idx));
      end
      @(posedge clk);
      #1 vif.voice_valid = 1'b0;
    end
  end

  task automatic pack_gains();
    for (int v = 0; v < NV; v++) gain_in[v*GW +: GW] = GW'(gains[v]);
  endtask

  task automatic pulse_tick();
    @(posedge clk); #1 tick = 1'b1;
    @(posedge clk); #1 tick = 1'b0;
  endtask

  task automatic wait_mix(output int lat);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (mix_valid !== 1'b1 && lat < 3000);
    check("mix_seen", int'(mix_valid), 1);
  endtask

  task automatic do_reset();
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    exp_clips = 0;
  endtask

  task automatic run_frame(input int exp_lat);
    int lat;
    int a;
    pack_gains();
    a = ref_acc();
    if ((a > 32767 || a < -32768) && exp_clips < 65535) exp_clips++;
    pulse_tick();
    wait_mix(lat);
    check("mix_out", int'(mix_out), clip16(a));
    if (exp_lat > 0) check("latency", lat, exp_lat);
    @(negedge clk);
    check("mix_valid_pulse", int'(mix_valid), 0);
    check("busy_after", int'(busy), 0);
`ifdef VOICE_MIX_CLIP_COUNT_EN
    check("clip_count", int'(clip_count), exp_clips);
`endif
  endtask

  task automatic count_quiet(input string tag, input int cycles);
    int pulses = 0;
    int reqs = 0;
    repeat (cycles) begin
      @(negedge clk);
      if (mix_valid === 1'b1) pulses++;
      if (vif.voice_req === 1'b1) reqs++;
    end
    check({tag, "_no_mix"}, pulses, 0);
    check({tag, "_no_req"}, reqs, 0);
  endtask

  initial begin : watchdog
    #5_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int lat;
    int found;
    rst = 1'b1; tick = 1'b0; gain_in = '0;
    vif.voice_valid = 1'b0; vif.voice_sample = '0;
    fix_delay = 1; exp_clips = 0;
    samples = '{0, 0, 0, 0};
    gains   = '{0, 0, 0, 0};
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    @(negedge clk);
    check("rst_voice_req", int'(vif.voice_req), 0);
    check("rst_voice_idx", int'(vif.voice_idx), 0);
    check("rst_mix_out", int'(mix_out), 0);
    check("rst_mix_valid", int'(mix_valid), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_overrun", int'(overrun), 0);
`ifdef VOICE_MIX_CLIP_COUNT_EN
    check("rst_clip_count", int'(clip_count), 0);
`endif

    // Unity gains, D=1
    samples = '{100, 200, -50, 10};
    gains   = '{128, 128, 128, 128};
    run_frame(9);
    check("t1_mix_260", int'(mix_out), 260);

    // Positive and negative saturation
    samples = '{30000, 30000, 30000, 30000};
    run_frame(9);
    check("t2_pos_sat", int'(mix_out), 32767);
    samples = '{-30000, -30000, -30000, -30000};
    run_frame(9);
    check("t2_neg_sat", int'(mix_out), -32768);

    // Gain scaling with floor rounding, longer fixed delay
    fix_delay = 3;
    samples = '{1000, 0, 0, 0};
    gains   = '{255, 0, 0, 0};
    run_frame(17);
    check("t3_gain255", int'(mix_out), 1992);
    samples = '{0, -1000, 0, 0};
    gains   = '{0, 64, 0, 0};
    run_frame(17);
    check("t3_gain64", int'(mix_out), -500);
    samples = '{-1, 1, -32768, 32767};
    gains   = '{1, 127, 255, 255};
    run_frame(17);

    // Second tick three cycles into a frame is dropped and flags overrun
    fix_delay = 2;
    samples = '{1234, -567, 89, 4000};
    gains   = '{200, 100, 50, 128};
    pack_gains();
    @(posedge clk); #1 tick = 1'b1;
    @(posedge clk); #1 tick = 1'b0;
    @(posedge clk);
    @(posedge clk); #1 tick = 1'b1;
    @(posedge clk); #1 tick = 1'b0;
    wait_mix(lat);
    check("t4_mix", int'(mix_out), clip16(ref_acc()));
    count_quiet("t4_drop", 40);
    check("t4_overrun", int'(overrun), 1);
    run_frame(13);
    check("t4_overrun_sticky", int'(overrun), 1);

    // Tick landing on the CLIP cycle is dropped too
    do_reset();
    @(negedge clk);
    check("t4_overrun_cleared", int'(overrun), 0);
    pulse_tick();
    wait_mix(lat);
    check("t4b_latency", lat, 13);
    tick = 1'b1;
    @(posedge clk); #1 tick = 1'b0;
    @(negedge clk);
    check("t4b_overrun", int'(overrun), 1);
    check("t4b_busy", int'(busy), 0);
    count_quiet("t4b_drop", 40);

    // Reset while waiting on voice 2 aborts the frame
    do_reset();
    fix_delay = 5;
    samples = '{5000, 6000, 7000, 8000};
    gains   = '{128, 128, 128, 128};
    pack_gains();
    pulse_tick();
    found = 0;
    for (int c = 0; c < 200 && found == 0; c++) begin
      @(negedge clk);
      if (vif.voice_idx == 2 && vif.voice_req == 1'b0 && busy == 1'b1) found = 1;
    end
    check("t5_reached_wait2", found, 1);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1;
    check("t5_voice_req", int'(vif.voice_req), 0);
    check("t5_voice_idx", int'(vif.voice_idx), 0);
    check("t5_mix_out", int'(mix_out), 0);
    check("t5_mix_valid", int'(mix_valid), 0);
    check("t5_busy", int'(busy), 0);
    check("t5_overrun", int'(overrun), 0);
`ifdef VOICE_MIX_CLIP_COUNT_EN
    check("t5_clip_count", int'(clip_count), 0);
`endif
    rst = 1'b0;
    exp_clips = 0;
    count_quiet("t5_abort", 40);
    samples = '{-300, 700, 1100, -2500};
    gains   = '{128, 64, 255, 10};
    run_frame(25);

    // Random samples, gains and return delays
    fix_delay = 0;
    for (int f = 0; f < 1000; f++) begin
      for (int v = 0; v < NV; v++) begin
        if ($urandom_range(3) == 0) samples[v] = int'($signed(16'($urandom)));
        else                        samples[v] = int'($urandom_range(4000)) - 2000;
        gains[v] = int'($urandom_range(255));
      end
      run_frame(0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
